// File: rtl/xbus_arbiter_pkg.sv
// Shared definitions for the xbus arbiter: FSM states, master ids, latency counter width.
package xbus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    // Read-latency counter width; covers RD_LAT up to 7.
    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/xbus_arbiter_pick2.sv
// Combinational two-way round-robin picker: a lone request wins, a tie goes to
// whichever master did not win last time.
module xrr_pick2
    import xbus_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant,
    output logic       o_valid
);

    // Pick the winner from the current requests and the previous owner.
    always_comb begin
        o_valid = |i_req;
        o_grant = M0;
        if (&i_req) begin
            o_grant = ~i_last;
        end else if (i_req[1]) begin
            o_grant = M1;
        end
    end

endmodule

// File: rtl/xbus_arbiter.sv
// Two-master bus arbiter/sequencer: round-robin grant, one registered access per
// grant, select held through the slave read latency, response with data and trap flag.
module xbus_arbiter
    import xbus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              s_sel,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_trap,
    output logic              grant
);

    // Counter preload for the WAIT phase; unused when there is no read latency.
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD =
        (RD_LAT > 0) ? LAT_CNT_W'(RD_LAT - 1) : '0;

    state_t               r_state;
    state_t               w_next;
    logic                 r_grant;
    logic                 r_last;
    logic                 r_trap;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata0;
    logic [DATA_W-1:0]    r_rdata1;
    logic                 r_err0;
    logic                 r_err1;
    logic                 w_pick_grant;
    logic                 w_pick_valid;
    logic                 w_last_sel;
    logic                 w_trap_now;

    xrr_pick2 u_pick (
        .i_req   ({m1_req, m0_req}),
        .i_last  (r_last),
        .o_grant (w_pick_grant),
        .o_valid (w_pick_valid)
    );

    // Next state plus bus/ack outputs decoded from the current state.
    always_comb begin
        w_next     = r_state;
        w_last_sel = 1'b0;
        w_trap_now = r_trap;
        s_sel      = 1'b0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_wdata    = '0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) w_next = ST_ACCESS;
            end
            ST_ACCESS: begin
                s_sel   = 1'b1;
                s_we    = r_we;
                s_addr  = r_addr;
                s_wdata = r_wdata;
                if (RD_LAT == 0) begin
                    // No latency: this is the last selected cycle, trap is live now.
                    w_next     = ST_RESP;
                    w_last_sel = 1'b1;
                    w_trap_now = s_trap;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                s_sel   = 1'b1;
                s_addr  = r_addr;
                s_wdata = r_wdata;
                if (r_cnt == '0) begin
                    w_next     = ST_RESP;
                    w_last_sel = 1'b1;
                end
            end
            ST_RESP: begin
                m0_ack = (r_grant == M0);
                m1_ack = (r_grant == M1);
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Control state: FSM, grant history, latency counter, trap flag and master responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_grant  <= M0;
            r_last   <= M1;
            r_trap   <= 1'b0;
            r_cnt    <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_err0   <= 1'b0;
            r_err1   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && w_pick_valid) r_grant <= w_pick_grant;
            if (r_state == ST_ACCESS) begin
                r_trap <= s_trap;
                r_cnt  <= LAT_LOAD;
            end
            if (r_state == ST_WAIT) r_cnt <= r_cnt - 1'b1;
            if (w_last_sel) begin
                if (r_grant == M0) begin
                    r_err0 <= w_trap_now;
                    if (!r_we) r_rdata0 <= s_rdata;
                end else begin
                    r_err1 <= w_trap_now;
                    if (!r_we) r_rdata1 <= s_rdata;
                end
            end
            if (r_state == ST_RESP) r_last <= r_grant;
        end
    end

    // Access payload of the winning master, held for the whole transaction.
    always_ff @(posedge clk) begin
        if (r_state == ST_IDLE && w_pick_valid) begin
            r_we    <= (w_pick_grant == M1) ? m1_we    : m0_we;
            r_addr  <= (w_pick_grant == M1) ? m1_addr  : m0_addr;
            r_wdata <= (w_pick_grant == M1) ? m1_wdata : m0_wdata;
        end
    end

    assign grant    = r_grant;
    assign m0_rdata = r_rdata0;
    assign m1_rdata = r_rdata1;
    assign m0_err   = r_err0;
    assign m1_err   = r_err1;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Bench for xbus_arbiter: directed scenarios with literal expectations, then random
// two-master traffic checked every cycle against a transaction-level model.
module tb_xbus_arbiter;

    localparam int AW  = 13;
    localparam int DW  = 32;
    localparam int LAT = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m0_err, m1_ack, m1_err;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          s_sel, s_we, s_trap, grant;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic          z_m0_ack, z_m0_err, z_m1_ack, z_m1_err;
    logic [DW-1:0] z_m0_rdata, z_m1_rdata;
    logic          z_s_sel, z_s_we, z_grant;
    logic [AW-1:0] z_s_addr;
    logic [DW-1:0] z_s_wdata;

    always #5 clk = ~clk;

    xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_sel(s_sel), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_trap(s_trap), .grant(grant)
    );

    xbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(0)) dut_z (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(z_m0_ack), .m0_rdata(z_m0_rdata), .m0_err(z_m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(z_m1_ack), .m1_rdata(z_m1_rdata), .m1_err(z_m1_err),
        .s_sel(z_s_sel), .s_we(z_s_we), .s_addr(z_s_addr), .s_wdata(z_s_wdata),
        .s_rdata(s_rdata), .s_trap(s_trap), .grant(z_grant)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level model: mk = cycles since the grant (0 = idle).
    int            mk;
    logic          mown, mlast, mgrant, mwe, mtrap, mw;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwdata;
    logic [DW-1:0] mrd [2];
    logic          merr [2];
    logic          e_ack [2];
    bit            mvalid = 0;

    // Values sampled from the DUTs in the current cycle.
    logic          smp_sel, smp_we, smp_ack0, smp_ack1, smp_err0, smp_err1, smp_grant;
    logic [AW-1:0] smp_addr;
    logic [DW-1:0] smp_wdata, smp_rd0, smp_rd1;
    logic          zs_sel, zs_ack0;
    logic [DW-1:0] zs_rd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            mk = 0; mlast = 1'b1; mgrant = 1'b0; mtrap = 1'b0;
            mrd[0] = '0; mrd[1] = '0; merr[0] = 1'b0; merr[1] = 1'b0;
            mvalid = 1;
        end else if (mk == 0) begin
            if (m0_req || m1_req) begin
                mw     = (m0_req && m1_req) ? !mlast : m1_req;
                mown   = mw;
                mgrant = mw;
                mwe    = mw ? m1_we    : m0_we;
                maddr  = mw ? m1_addr  : m0_addr;
                mwdata = mw ? m1_wdata : m0_wdata;
                mk     = 1;
            end
        end else if (mk == 2 + LAT) begin
            mlast = mown;
            mk    = 0;
        end else begin
            if (mk == 1) mtrap = s_trap;
            if (mk == 1 + LAT) begin
                merr[mown] = mtrap;
                if (!mwe) mrd[mown] = s_rdata;
            end
            mk++;
        end
    endtask

    // One clock cycle: inputs already driven; sample, compare to model, advance model.
    task automatic step();
        logic e_sel;
        #1;
        smp_sel = s_sel; smp_we = s_we; smp_addr = s_addr; smp_wdata = s_wdata;
        smp_ack0 = m0_ack; smp_ack1 = m1_ack; smp_rd0 = m0_rdata; smp_rd1 = m1_rdata;
        smp_err0 = m0_err; smp_err1 = m1_err; smp_grant = grant;
        zs_sel = z_s_sel; zs_ack0 = z_m0_ack; zs_rd0 = z_m0_rdata;
        e_sel    = (mk >= 1) && (mk <= 1 + LAT);
        e_ack[0] = (mk == 2 + LAT) && (mown == 1'b0);
        e_ack[1] = (mk == 2 + LAT) && (mown == 1'b1);
        if (mvalid) begin
            chk("s_sel", smp_sel, e_sel);
            chk("s_we", smp_we, (mk == 1) && mwe);
            chk("s_addr", smp_addr, e_sel ? maddr : '0);
            chk("s_wdata", smp_wdata, e_sel ? mwdata : '0);
            chk("m0_ack", smp_ack0, e_ack[0]);
            chk("m1_ack", smp_ack1, e_ack[1]);
            chk("m0_rdata", smp_rd0, mrd[0]);
            chk("m1_rdata", smp_rd1, mrd[1]);
            chk("m0_err", smp_err0, merr[0]);
            chk("m1_err", smp_err1, merr[1]);
            chk("grant", smp_grant, mgrant);
        end
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    // Single directed transaction for one master; bounded wait for its ack.
    task automatic xact(input bit m, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd, input bit trap,
                        output int ack_cyc, output int sel_cnt, output int we_cnt,
                        output logic [DW-1:0] wd_seen, output logic [AW-1:0] a_seen,
                        output int other_ack);
        ack_cyc = -1; sel_cnt = 0; we_cnt = 0; wd_seen = '0; a_seen = '0; other_ack = 0;
        if (m) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = wd; end
        else   begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = wd; end
        s_rdata = rd; s_trap = trap;
        for (int i = 0; i < 12 && ack_cyc < 0; i++) begin
            step();
            if (smp_sel) begin sel_cnt++; a_seen = smp_addr; end
            if (smp_we) begin we_cnt++; wd_seen = smp_wdata; end
            if (m ? smp_ack1 : smp_ack0) ack_cyc = i;
            if (m ? smp_ack0 : smp_ack1) other_ack++;
        end
        m0_req = 0; m1_req = 0; s_trap = 0;
    endtask

    int            ack_c, sel_c, we_c, oth, zack, zsel, mack, nacks;
    logic [DW-1:0] wd_s, zrd, mrd0;
    logic [AW-1:0] a_s;
    logic          order [$];
    bit            pend [2];
    logic          ag_we [2];
    logic [AW-1:0] ag_addr [2];
    logic [DW-1:0] ag_wdata [2];

    initial begin
        rst = 1; m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; s_rdata = '0; s_trap = 0;
        @(negedge clk);
        step(); step();
        chk("reset_sel", smp_sel, 1'b0);
        chk("reset_ack0", smp_ack0, 1'b0);
        chk("reset_grant", smp_grant, 1'b0);
        chk("reset_rdata0", smp_rd0, 32'h0);
        rst = 0;

        // m0 read
        xact(0, 0, 13'h010, 32'h0, 32'hDEADBEEF, 0, ack_c, sel_c, we_c, wd_s, a_s, oth);
        chk("t1_ack_cycle", ack_c, 3);
        chk("t1_sel_cycles", sel_c, 2);
        chk("t1_we_cycles", we_c, 0);
        chk("t1_addr", a_s, 13'h010);
        chk("t1_rdata", smp_rd0, 32'hDEADBEEF);
        chk("t1_err", smp_err0, 1'b0);

        // m1 write
        xact(1, 1, 13'h020, 32'h12345678, 32'hCAFEF00D, 0, ack_c, sel_c, we_c, wd_s, a_s, oth);
        chk("t2_ack_cycle", ack_c, 3);
        chk("t2_we_cycles", we_c, 1);
        chk("t2_wdata", wd_s, 32'h12345678);
        chk("t2_m0_ack", oth, 0);
        chk("t2_m0_rdata", smp_rd0, 32'hDEADBEEF);
        chk("t2_m1_rdata", smp_rd1, 32'h0);
        chk("t2_grant", smp_grant, 1'b1);

        // trap then good access
        xact(0, 0, 13'h1FFF, 32'h0, 32'h55, 1, ack_c, sel_c, we_c, wd_s, a_s, oth);
        chk("t4_trap_ack", ack_c, 3);
        chk("t4_trap_err", smp_err0, 1'b1);
        xact(0, 0, 13'h004, 32'h0, 32'h66, 0, ack_c, sel_c, we_c, wd_s, a_s, oth);
        chk("t4_good_err", smp_err0, 1'b0);
        chk("t4_good_rdata", smp_rd0, 32'h66);

        // both request from reset, held
        rst = 1; step(); rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 13'h100;
        m1_req = 1; m1_we = 0; m1_addr = 13'h200;
        s_rdata = 32'h77;
        for (int i = 0; i < 16; i++) begin
            step();
            if (smp_ack0) order.push_back(1'b0);
            if (smp_ack1) order.push_back(1'b1);
        end
        m0_req = 0; m1_req = 0;
        nacks = order.size();
        chk("t3_ack_count", nacks, 4);
        for (int i = 0; i < 4 && i < nacks; i++) chk("t3_order", order[i], (i % 2) != 0);
        step();

        // reset during WAIT
        rst = 1; step(); rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 13'h030; s_rdata = 32'h99;
        step(); step();
        rst = 1; step(); rst = 0;
        step();
        chk("t5_sel_after_rst", smp_sel, 1'b0);
        chk("t5_no_ack", smp_ack0, 1'b0);
        mack = -1;
        for (int i = 4; i < 14 && mack < 0; i++) begin
            step();
            if (smp_ack0) mack = i;
        end
        chk("t5_reservice_ack", mack, 6);
        chk("t5_rdata", smp_rd0, 32'h99);
        m0_req = 0;
        step();

        // zero-latency build alongside the default build
        rst = 1; step(); rst = 0;
        m0_req = 1; m0_we = 0; m0_addr = 13'h040;
        zack = -1; zsel = 0; mack = -1; zrd = '0; mrd0 = '0;
        for (int c = 0; c < 8 && mack < 0; c++) begin
            s_rdata = 32'hA0000000 + DW'(c);
            step();
            if (zack < 0 && zs_sel) zsel++;
            if (zack < 0 && zs_ack0) begin zack = c; zrd = zs_rd0; end
            if (smp_ack0) begin mack = c; mrd0 = smp_rd0; end
        end
        m0_req = 0;
        chk("t6_z_ack_cycle", zack, 2);
        chk("t6_z_sel_cycles", zsel, 1);
        chk("t6_z_rdata", zrd, 32'hA0000001);
        chk("t6_ack_cycle", mack, 3);
        chk("t6_rdata", mrd0, 32'hA0000002);

        // random traffic
        rst = 1; step(); rst = 0;
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom % 250) == 0;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom % 3) == 0) begin
                    pend[i] = 1; ag_we[i] = $urandom % 2;
                    ag_addr[i] = AW'($urandom); ag_wdata[i] = $urandom;
                end else if (pend[i] && ($urandom % 40) == 0) begin
                    pend[i] = 0;
                end
            end
            m0_req = pend[0]; m0_we = ag_we[0]; m0_addr = ag_addr[0]; m0_wdata = ag_wdata[0];
            m1_req = pend[1]; m1_we = ag_we[1]; m1_addr = ag_addr[1]; m1_wdata = ag_wdata[1];
            s_rdata = $urandom; s_trap = ($urandom % 4) == 0;
            step();
            for (int i = 0; i < 2; i++) if (e_ack[i]) pend[i] = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
